alu_seq: RTL

Parametrised, handshaked successor to the team's 32-bit combinational ALU. Operand width is set by `WIDTH`, and operands and results move over valid/ready handshakes. Results are registered, and the block adds shift, unsigned-compare and an optional multi-cycle multiply. It sits between the operand/issue stage and the writeback stage of the datapath.

---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with logic, add/sub, compares, shifts and an optional
// shift-add multiplier (compiled in when ALU_SEQ_MUL_EN is defined).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1000;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef ALU_SEQ_MUL_EN
        S_BUSY,
`endif
        S_HOLD
    } state_t;

    state_t state;
    // Holds in_ready low for the first cycle after reset releases.
    logic rdy_en;
    logic accept;

    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   c_res;
    logic               c_cout;
    logic               c_ovf;
    logic               c_ill;

`ifdef ALU_SEQ_MUL_EN
    logic               c_mul;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [SHW:0]       cnt;
    logic [WIDTH:0]     psum;
`endif

    assign in_ready = rdy_en && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        add_s  = {1'b0, a} + {1'b0, b};
        sub_s  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        sh     = b[SHW-1:0];
        c_res  = '0;
        c_cout = 1'b0;
        c_ovf  = 1'b0;
        c_ill  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        c_mul  = 1'b0;
`endif
        case (opcode)
            OP_AND:  c_res = a & b;
            OP_OR:   c_res = a | b;
            OP_XOR:  c_res = a ^ b;
            OP_NOR:  c_res = ~(a | b);
            OP_ADD: begin
                c_res  = add_s[WIDTH-1:0];
                c_cout = add_s[WIDTH];
                c_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                c_res  = sub_s[WIDTH-1:0];
                c_cout = sub_s[WIDTH];
                c_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: c_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  c_res = a << sh;
            OP_SRL:  c_res = a >> sh;
            OP_SRA:  c_res = $unsigned($signed(a) >>> sh);
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  c_mul = 1'b1;
`endif
            default: c_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add step: conditionally add the multiplicand into the high half, then shift right.
    always_comb begin
        psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rdy_en    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod      <= '0;
            mcand     <= '0;
            cnt       <= '0;
`endif
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                        if (c_mul) begin
                            prod      <= {{WIDTH{1'b0}}, b};
                            mcand     <= a;
                            cnt       <= (SHW+1)'(WIDTH);
                            out_valid <= 1'b0;
                            state     <= S_BUSY;
                        end else begin
`endif
                            result    <= c_res;
                            cout      <= c_cout;
                            overflow  <= c_ovf;
                            zero      <= (c_res == '0) && !c_ill;
                            illegal   <= c_ill;
                            out_valid <= 1'b1;
                            state     <= S_HOLD;
`ifdef ALU_SEQ_MUL_EN
                        end
`endif
                    end else if ((state == S_HOLD) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                S_BUSY: begin
                    if (cnt == '0) begin
                        result    <= prod[WIDTH-1:0];
                        cout      <= 1'b0;
                        overflow  <= |prod[2*WIDTH-1:WIDTH];
                        zero      <= (prod[WIDTH-1:0] == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        prod <= {psum, prod[WIDTH-1:1]};
                        cnt  <= cnt - 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
